// File: rtl/mem_sched_pkg.sv
// Shared constants for the memory scheduler: bus widths, burst length,
// tag field layout, requester ids and the FSM state encoding.
package mem_sched_pkg;

  localparam int MEM_ADDR_BITS   = 32;
  localparam int MEM_TAG_BITS    = 5;
  localparam int MEM_DATA_BITS   = 64;
  localparam int MEM_MASK_BITS   = MEM_DATA_BITS / 8;
  localparam int MEM_DATA_CYCLES = 4;

  localparam int BEAT_BITS = (MEM_DATA_CYCLES > 1) ? $clog2(MEM_DATA_CYCLES) : 1;
  localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(MEM_DATA_CYCLES - 1);

  // Tag layout: bit0 = requester id, bits[3:1] = issue sequence, rest zero.
  localparam int TAG_ID_BIT   = 0;
  localparam int TAG_SEQ_LSB  = 1;
  localparam int TAG_SEQ_BITS = 3;

  localparam logic REQ_ID_IC = 1'b0;
  localparam logic REQ_ID_DC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WDATA = 2'd2
  } state_t;

  function automatic logic [MEM_TAG_BITS-1:0] make_tag(input logic id,
                                                       input logic [TAG_SEQ_BITS-1:0] seq);
    logic [MEM_TAG_BITS-1:0] t;
    t = '0;
    t[TAG_ID_BIT] = id;
    t[TAG_SEQ_LSB +: TAG_SEQ_BITS] = seq;
    return t;
  endfunction

endpackage

// File: rtl/mem_sched_rr_arb2.sv
// Two-way requester picker (index 0 = icache, 1 = dcache).
// MEM_SCHED_RR_EN defined: round-robin with a last-grant register, icache
// first after reset. Undefined: fixed priority, dcache wins; no state kept.
module rr_arb2 (
`ifdef MEM_SCHED_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef MEM_SCHED_RR_EN
  logic last_dc;

  // On a tie, grant whichever side did not win last time.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_dc ? 2'b01 : 2'b10;
  end

  // Remember the last winner; reset value makes icache win the first tie.
  always_ff @(posedge clk) begin
    if (reset)    last_dc <= 1'b1;
    else if (|gnt) last_dc <= gnt[1];
  end
`else
  // Fixed priority: dcache always beats icache.
  always_comb begin
    gnt = req[1] ? 2'b10 : {1'b0, req[0]};
  end
`endif

endmodule

// File: rtl/mem_sched.sv
// Memory scheduler: arbitrates icache refills and dcache refill/write-back
// commands onto one main-memory port, forwards write beats and routes
// response beats by tag. Build option: MEM_SCHED_RR_EN selects round-robin
// arbitration instead of fixed dcache priority.
//
// state    | meaning
// ST_IDLE  | pick an eligible requester, capture its command
// ST_ISSUE | present captured command until mem_req_ready
// ST_WDATA | forward MEM_DATA_CYCLES dcache write beats
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ic_req_valid,
  output logic                     ic_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] ic_req_addr,
  output logic                     ic_resp_valid,
  input  logic                     dc_req_valid,
  output logic                     dc_req_ready,
  input  logic                     dc_req_rw,
  input  logic [MEM_ADDR_BITS-1:0] dc_req_addr,
  input  logic                     dc_req_data_valid,
  output logic                     dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] dc_req_data_mask,
  output logic                     dc_resp_valid,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]  mem_req_tag,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]  mem_resp_tag
);

  state_t                  state;
  logic [TAG_SEQ_BITS-1:0] seq_q;
  logic [BEAT_BITS-1:0]    wbeat;
  logic [2:0]              ic_out, dc_out;
  logic [BEAT_BITS-1:0]    ic_beat, dc_beat;
  logic                    in_idle, in_wdata;
  logic                    ic_elig, dc_elig;
  logic [1:0]              gnt;
  logic                    ic_inc, dc_inc, ic_dec, dc_dec;
  logic                    wbeat_hs;
  logic                    unused_resp_tag_hi;

  // Eligibility, handshakes, write pass-through and response routing.
  always_comb begin
    in_idle  = (state == ST_IDLE);
    in_wdata = (state == ST_WDATA);
    ic_elig  = in_idle & ic_req_valid & (ic_out < 3'(MAX_OUT));
    dc_elig  = in_idle & dc_req_valid & (dc_req_rw | (dc_out < 3'(MAX_OUT)));

    mem_req_data_valid = in_wdata & dc_req_data_valid;
    dc_req_data_ready  = in_wdata & mem_req_data_ready;
    mem_req_data_bits  = in_wdata ? dc_req_data_bits : '0;
    mem_req_data_mask  = in_wdata ? dc_req_data_mask : '0;
    wbeat_hs           = mem_req_data_valid & mem_req_data_ready;

    ic_resp_valid = mem_resp_valid & ~mem_resp_tag[TAG_ID_BIT];
    dc_resp_valid = mem_resp_valid &  mem_resp_tag[TAG_ID_BIT];

    ic_inc = gnt[0];
    dc_inc = gnt[1] & ~dc_req_rw;
    ic_dec = ic_resp_valid & (ic_beat == BEAT_LAST);
    dc_dec = dc_resp_valid & (dc_beat == BEAT_LAST);
  end

  assign ic_req_ready       = gnt[0];
  assign dc_req_ready       = gnt[1];
  assign unused_resp_tag_hi = ^mem_resp_tag[MEM_TAG_BITS-1:1];

  rr_arb2 u_arb (
`ifdef MEM_SCHED_RR_EN
    .clk   (clk),
    .reset (reset),
`endif
    .req   ({dc_elig, ic_elig}),
    .gnt   (gnt)
  );

  // Command FSM with registered memory-command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_tag   <= '0;
      seq_q         <= '0;
      wbeat         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            mem_req_valid <= 1'b1;
            seq_q         <= seq_q + 1'b1;
            state         <= ST_ISSUE;
            if (gnt[1]) begin
              mem_req_rw   <= dc_req_rw;
              mem_req_addr <= dc_req_addr;
              mem_req_tag  <= make_tag(REQ_ID_DC, seq_q);
            end else begin
              mem_req_rw   <= 1'b0;
              mem_req_addr <= ic_req_addr;
              mem_req_tag  <= make_tag(REQ_ID_IC, seq_q);
            end
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= mem_req_rw ? ST_WDATA : ST_IDLE;
          end
        end
        ST_WDATA: begin
          if (wbeat_hs) begin
            if (wbeat == BEAT_LAST) begin
              wbeat <= '0;
              state <= ST_IDLE;
            end else begin
              wbeat <= wbeat + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-read and response-beat bookkeeping, independent of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ic_out  <= '0;
      dc_out  <= '0;
      ic_beat <= '0;
      dc_beat <= '0;
    end else begin
      if (ic_inc & ~ic_dec)                    ic_out <= ic_out + 3'd1;
      else if (~ic_inc & ic_dec & (ic_out != 0)) ic_out <= ic_out - 3'd1;
      if (dc_inc & ~dc_dec)                    dc_out <= dc_out + 3'd1;
      else if (~dc_inc & dc_dec & (dc_out != 0)) dc_out <= dc_out - 3'd1;
      if (ic_resp_valid) ic_beat <= ic_dec ? '0 : ic_beat + 1'b1;
      if (dc_resp_valid) dc_beat <= dc_dec ? '0 : dc_beat + 1'b1;
    end
  end

endmodule
